// File: rtl/ex_stage.sv
// Execute stage of the RV32IM core.
// Single-cycle RV32I ALU, LUI and RV32M multiply; iterative restoring divider
// for DIV/DIVU/REM/REMU that holds the upstream stage via stall_o.
// Produces one registered register-file write per retired instruction.
//
// Handshake: the stage accepts inst_i/op1_i/op2_i/rd_* on any rising edge where
// valid_i=1, flush_i=0, rst=1 and the stage is IDLE. While stall_o=1 upstream
// holds every input stable; inputs are not sampled during a divide.
// flush_i cancels both the instruction on the inputs and any divide in flight.
module ex_stage #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_wen_i,
    output logic        stall_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        reg_wen_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam int         CNT_W      = $clog2(DIV_ITERS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r, is_m, is_i, is_lui, is_div;
    logic       div_signed, div_rem, div_by_zero, div_ovf, start_div;

    // Classify the incoming instruction and spot divide special cases.
    always_comb begin
        opcode      = inst_i[6:0];
        funct3      = inst_i[14:12];
        funct7      = inst_i[31:25];
        is_r        = (opcode == OPC_OP) && ((funct7 == 7'h00) || (funct7 == 7'h20));
        is_m        = (opcode == OPC_OP) && (funct7 == 7'h01);
        is_i        = (opcode == OPC_OP_IMM);
        is_lui      = (opcode == OPC_LUI);
        is_div      = is_m && funct3[2];
        div_signed  = !funct3[0];
        div_rem     = funct3[1];
        div_by_zero = (op2_i == 32'h0);
        div_ovf     = div_signed && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
        start_div   = is_div && !div_by_zero && !div_ovf;
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] alu_res;
    logic [4:0]  shamt;

    // RV32I register/immediate arithmetic; SUB only exists for R-type.
    always_comb begin
        alu_res = 32'h0;
        shamt   = op2_i[4:0];
        case (funct3)
            3'd0: begin
                if (is_r && inst_i[30]) alu_res = op1_i - op2_i;
                else                    alu_res = op1_i + op2_i;
            end
            3'd1: alu_res = op1_i << shamt;
            3'd2: alu_res = {31'h0, ($signed(op1_i) < $signed(op2_i))};
            3'd3: alu_res = {31'h0, (op1_i < op2_i)};
            3'd4: alu_res = op1_i ^ op2_i;
            3'd5: begin
                if (inst_i[30]) alu_res = $signed(op1_i) >>> shamt;
                else            alu_res = op1_i >> shamt;
            end
            3'd6: alu_res = op1_i | op2_i;
            default: alu_res = op1_i & op2_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier: one shared product of operands extended per signedness
    // ------------------------------------------------------------------
    logic        mul_a_sgn, mul_b_sgn;
    logic [65:0] mul_a_ext, mul_b_ext, mul_prod;
    logic [31:0] mul_res;

    // MULH treats both signed, MULHSU only op1, MULHU neither; MUL uses low half.
    always_comb begin
        mul_a_sgn = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
        mul_b_sgn = (funct3[1:0] == 2'b01);
        mul_a_ext = {{34{mul_a_sgn & op1_i[31]}}, op1_i};
        mul_b_ext = {{34{mul_b_sgn & op2_i[31]}}, op2_i};
        mul_prod  = mul_a_ext * mul_b_ext;
        if (funct3[1:0] == 2'b00) mul_res = mul_prod[31:0];
        else                      mul_res = mul_prod[63:32];
    end

    // ------------------------------------------------------------------
    // Single-cycle result select
    // ------------------------------------------------------------------
    logic [31:0] sc_res;
    logic        sc_wr;

    // Result and write-qualify for everything that retires in one cycle.
    always_comb begin
        sc_res = 32'h0;
        sc_wr  = 1'b0;
        if (is_lui) begin
            sc_res = {inst_i[31:12], 12'h000};
            sc_wr  = 1'b1;
        end else if (is_r || is_i) begin
            sc_res = alu_res;
            sc_wr  = 1'b1;
        end else if (is_m) begin
            sc_wr = 1'b1;
            if (!funct3[2])     sc_res = mul_res;
            else if (div_by_zero) sc_res = div_rem ? op1_i : 32'hFFFF_FFFF;
            else                sc_res = div_rem ? 32'h0 : 32'h8000_0000;
        end
    end

    // ------------------------------------------------------------------
    // Divider state
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        quo_q, quo_d;
    logic [31:0]        rem_q, rem_d;
    logic [31:0]        dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_rem_q, is_rem_d;
    logic [4:0]         rd_q, rd_d;
    logic               rd_wen_q, rd_wen_d;
    logic               wen_q, wen_d;
    logic [4:0]         waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0] op1_abs, op2_abs;
    logic [32:0] step_shift, step_diff;
    logic        step_ge;
    logic [31:0] step_quo, step_rem, quo_fin, rem_fin;
    logic        div_last;

    // One restoring step: shift next dividend bit into the partial remainder,
    // subtract if it fits. Dividend bits drain out of the top of quo_q while
    // quotient bits fill in from the bottom.
    always_comb begin
        op1_abs    = (div_signed && op1_i[31]) ? (~op1_i + 32'd1) : op1_i;
        op2_abs    = (div_signed && op2_i[31]) ? (~op2_i + 32'd1) : op2_i;
        step_shift = {rem_q, quo_q[31]};
        step_diff  = step_shift - {1'b0, dvs_q};
        step_ge    = !step_diff[32];
        step_rem   = step_ge ? step_diff[31:0] : step_shift[31:0];
        step_quo   = {quo_q[30:0], step_ge};
        quo_fin    = neg_quo_q ? (~step_quo + 32'd1) : step_quo;
        rem_fin    = neg_rem_q ? (~step_rem + 32'd1) : step_rem;
        div_last   = (cnt_q == CNT_W'(DIV_ITERS - 1));
    end

    // Stall while a divide is being accepted or iterating; flush and reset win.
    always_comb begin
        stall_o = rst && !flush_i &&
                  ((state_q == ST_DIV) || (valid_i && start_div));
    end

    // Next-state: accept, iterate, retire; write enable is a one-cycle pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i && start_div) begin
                        state_d   = ST_DIV;
                        cnt_d     = '0;
                        quo_d     = op1_abs;
                        rem_d     = 32'h0;
                        dvs_d     = op2_abs;
                        neg_quo_d = div_signed && (op1_i[31] ^ op2_i[31]);
                        neg_rem_d = div_signed && op1_i[31];
                        is_rem_d  = div_rem;
                        rd_d      = rd_addr_i;
                        rd_wen_d  = rd_wen_i;
                    end else if (valid_i && sc_wr && rd_wen_i && (rd_addr_i != 5'd0)) begin
                        wen_d   = 1'b1;
                        waddr_d = rd_addr_i;
                        wdata_d = sc_res;
                    end
                end
                default: begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (div_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (rd_wen_q && (rd_q != 5'd0)) begin
                            wen_d   = 1'b1;
                            waddr_d = rd_q;
                            wdata_d = is_rem_q ? rem_fin : quo_fin;
                        end
                    end
                end
            endcase
        end
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quo_q     <= 32'h0;
            rem_q     <= 32'h0;
            dvs_q     <= 32'h0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            rd_q      <= 5'd0;
            rd_wen_q  <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
            rd_q      <= rd_d;
            rd_wen_q  <= rd_wen_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign reg_wen_o   = wen_q;
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = wdata_q;

    // rd field comes in separately on rd_addr_i; product bits above 63 are unused.
    logic unused_bits;
    assign unused_bits = ^{inst_i[11:7], mul_prod[65:64]};

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed and randomised instructions, expected writes
// queued at issue and compared when reg_wen_o pulses.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] inst_i = 32'h0;
    logic [31:0] op1_i = 32'h0;
    logic [31:0] op2_i = 32'h0;
    logic [4:0]  rd_addr_i = 5'd0;
    logic        rd_wen_i = 1'b0;
    logic        stall_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_wen_o;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_item;

    ex_stage #(.DIV_ITERS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .flush_i    (flush_i),
        .inst_i     (inst_i),
        .op1_i      (op1_i),
        .op2_i      (op2_i),
        .rd_addr_i  (rd_addr_i),
        .rd_wen_i   (rd_wen_i),
        .stall_o    (stall_o),
        .reg_waddr_o(reg_waddr_o),
        .reg_wdata_o(reg_wdata_o),
        .reg_wen_o  (reg_wen_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reg_wen_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got waddr=%0d wdata=%h, required no write",
                         reg_waddr_o, reg_wdata_o);
            end else begin
                exp_item = exp_q.pop_front();
                if ({reg_waddr_o, reg_wdata_o} !== exp_item) begin
                    errors++;
                    $display("FAIL wb_data: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                             reg_waddr_o, reg_wdata_o, exp_item[36:32], exp_item[31:0]);
                end
            end
        end
    end

    // Instruction builders
    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd0, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd0, 7'b0010011};
    endfunction

    function automatic logic [31:0] lui_op(input logic [19:0] imm);
        return {imm, 5'd0, 7'b0110111};
    endfunction

    // Reference model: {writes, value}
    function automatic logic [32:0] model(input logic [31:0] inst, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [6:0]      opc;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [31:0]     r;
        logic [63:0]     p;
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib;
        opc = inst[6:0];
        f3  = inst[14:12];
        f7  = inst[31:25];
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ia  = a;
        ib  = b;
        r   = 32'h0;
        if (opc == 7'b0110111) return {1'b1, inst[31:12], 12'h000};
        if (opc == 7'b0010011 || (opc == 7'b0110011 && (f7 == 7'h00 || f7 == 7'h20))) begin
            case (f3)
                3'd0: r = (opc == 7'b0110011 && inst[30]) ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = (ia < ib) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (inst[30]) r = ia >>> b[4:0];
                    else          r = a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
            return {1'b1, r};
        end
        if (opc == 7'b0110011 && f7 == 7'h01) begin
            case (f3)
                3'd0: begin p = ua * ub; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
                3'd3: begin p = ua * ub; r = p[63:32]; end
                3'd4, 3'd5: begin
                    if (b == 32'h0) r = 32'hFFFF_FFFF;
                    else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                    else if (!f3[0]) r = ia / ib;
                    else r = a / b;
                end
                default: begin
                    if (b == 32'h0) r = a;
                    else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                    else if (!f3[0]) r = ia % ib;
                    else r = a % b;
                end
            endcase
            return {1'b1, r};
        end
        return {1'b0, 32'h0};
    endfunction

    // Driver: one single-cycle instruction, accepted at the next rising edge.
    task automatic issue1(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic rdw, input logic [32:0] exp);
        logic exp_wen;
        exp_wen   = exp[32] && rdw && (rd != 5'd0);
        inst_i    = inst;
        op1_i     = a;
        op2_i     = b;
        rd_addr_i = rd;
        rd_wen_i  = rdw;
        valid_i   = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_single: inst=%h got stall=%b, required 0", inst, stall_o);
        end
        if (exp_wen) exp_q.push_back({rd, exp[31:0]});
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (reg_wen_o !== exp_wen) begin
            errors++;
            $display("FAIL wen_next: inst=%h got wen=%b, required %b", inst, reg_wen_o, exp_wen);
        end
    endtask

    // Driver: full iterative divide with cycle-accurate stall/wen checks.
    task automatic run_div(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] exp_val);
        inst_i    = inst;
        op1_i     = a;
        op2_i     = b;
        rd_addr_i = rd;
        rd_wen_i  = 1'b1;
        valid_i   = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL div_accept_stall: got stall=%b, required 1", stall_o);
        end
        exp_q.push_back({rd, exp_val});
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            checks++;
            if (stall_o !== 1'b1 || reg_wen_o !== 1'b0) begin
                errors++;
                $display("FAIL div_busy: cycle T+%0d got stall=%b wen=%b, required stall=1 wen=0",
                         i, stall_o, reg_wen_o);
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        checks++;
        if (reg_wen_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL div_done: T+33 got wen=%b stall=%b, required wen=1 stall=0",
                     reg_wen_o, stall_o);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        inst_i    = r_op(7'h01, 3'd4);
        op1_i     = 32'd100;
        op2_i     = 32'd7;
        rd_addr_i = 5'd1;
        rd_wen_i  = 1'b1;
        valid_i   = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b, required 0", stall_o);
        end
        checks++;
        if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== 38'h0) begin
            errors++;
            $display("FAIL reset_outputs: got wen=%b waddr=%0d wdata=%h, required all 0",
                     reg_wen_o, reg_waddr_o, reg_wdata_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst     = 1'b1;
    endtask

    task automatic test_alu();
        logic [31:0] r_ops[9];
        logic [2:0]  i_f3[5];
        logic [31:0] a, b, inst;
        logic [11:0] imm;
        r_ops = '{r_op(7'h20, 3'd0), r_op(7'h00, 3'd1), r_op(7'h00, 3'd2), r_op(7'h00, 3'd3),
                  r_op(7'h00, 3'd4), r_op(7'h00, 3'd5), r_op(7'h20, 3'd5), r_op(7'h00, 3'd6),
                  r_op(7'h00, 3'd7)};
        i_f3  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd7};
        issue1(r_op(7'h00, 3'd0), 32'd5, 32'd7, 5'd3, 1'b1, {1'b1, 32'd12});
        issue1(r_op(7'h00, 3'd2), 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, {1'b1, 32'd1});
        issue1(r_op(7'h00, 3'd3), 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, {1'b1, 32'd0});
        issue1(r_op(7'h20, 3'd5), 32'h8000_0000, 32'd4, 5'd5, 1'b1, {1'b1, 32'hF800_0000});
        for (int k = 0; k < 2; k++) begin
            foreach (r_ops[j]) begin
                a = $urandom;
                b = $urandom;
                issue1(r_ops[j], a, b, 5'($urandom_range(1, 31)), 1'b1, model(r_ops[j], a, b));
            end
            foreach (i_f3[j]) begin
                imm  = 12'($urandom);
                a    = $urandom;
                b    = {{20{imm[11]}}, imm};
                inst = i_op(imm, i_f3[j]);
                issue1(inst, a, b, 5'($urandom_range(1, 31)), 1'b1, model(inst, a, b));
            end
            imm  = {7'h20, 5'($urandom)};
            a    = $urandom | 32'h8000_0000;
            b    = {{20{imm[11]}}, imm};
            inst = i_op(imm, 3'd5);
            issue1(inst, a, b, 5'd9, 1'b1, model(inst, a, b));
            inst = lui_op(20'($urandom));
            issue1(inst, 32'h0, 32'h0, 5'd10, 1'b1, model(inst, 32'h0, 32'h0));
        end
    endtask

    task automatic test_mul();
        logic [31:0] a, b, inst;
        issue1(r_op(7'h01, 3'd1), 32'h8000_0000, 32'd2, 5'd11, 1'b1, {1'b1, 32'hFFFF_FFFF});
        issue1(r_op(7'h01, 3'd3), 32'h8000_0000, 32'd2, 5'd12, 1'b1, {1'b1, 32'h0000_0001});
        issue1(r_op(7'h01, 3'd0), 32'h8000_0000, 32'd2, 5'd13, 1'b1, {1'b1, 32'h0000_0000});
        issue1(r_op(7'h01, 3'd2), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 1'b1, {1'b1, 32'hFFFF_FFFF});
        for (int k = 0; k < 12; k++) begin
            a    = $urandom;
            b    = $urandom;
            inst = r_op(7'h01, 3'(k % 4));
            issue1(inst, a, b, 5'($urandom_range(1, 31)), 1'b1, model(inst, a, b));
        end
    endtask

    task automatic test_div_special();
        issue1(r_op(7'h01, 3'd5), 32'd1234, 32'd0, 5'd15, 1'b1, {1'b1, 32'hFFFF_FFFF});
        issue1(r_op(7'h01, 3'd4), 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1, {1'b1, 32'h8000_0000});
        issue1(r_op(7'h01, 3'd6), 32'h0000_1234, 32'd0, 5'd17, 1'b1, {1'b1, 32'h0000_1234});
        issue1(r_op(7'h01, 3'd6), 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1'b1, {1'b1, 32'h0});
        issue1(r_op(7'h01, 3'd7), 32'hDEAD_BEEF, 32'd0, 5'd19, 1'b1, {1'b1, 32'hDEAD_BEEF});
        issue1(r_op(7'h01, 3'd4), 32'hFFFF_FF9C, 32'd0, 5'd20, 1'b1, {1'b1, 32'hFFFF_FFFF});
    endtask

    task automatic test_div();
        logic [31:0] a, b, inst;
        run_div(r_op(7'h01, 3'd4), 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFF2);
        run_div(r_op(7'h01, 3'd6), 32'hFFFF_FF9C, 32'd7, 5'd8, 32'hFFFF_FFFE);
        run_div(r_op(7'h01, 3'd5), 32'd100, 32'd9, 5'd21, 32'd11);
        run_div(r_op(7'h01, 3'd4), 32'd100, 32'hFFFF_FFF9, 5'd22, 32'hFFFF_FFF2);
        for (int k = 4; k < 8; k++) begin
            a    = $urandom;
            b    = $urandom >> $urandom_range(0, 28);
            if (b == 32'h0 || b == 32'hFFFF_FFFF) b = 32'd3;
            inst = r_op(7'h01, 3'(k));
            run_div(inst, a, b, 5'($urandom_range(1, 31)), model(inst, a, b) & 33'h0_FFFF_FFFF);
        end
    endtask

    task automatic test_back_to_back();
        run_div(r_op(7'h01, 3'd7), 32'd1000, 32'd7, 5'd23, 32'd6);
        issue1(r_op(7'h00, 3'd0), 32'd40, 32'd2, 5'd24, 1'b1, {1'b1, 32'd42});
        issue1(r_op(7'h00, 3'd6), 32'hF0, 32'h0F, 5'd25, 1'b1, {1'b1, 32'hFF});
    endtask

    task automatic test_flush();
        inst_i    = r_op(7'h01, 3'd4);
        op1_i     = 32'hFFFF_FF9C;
        op2_i     = 32'd7;
        rd_addr_i = 5'd26;
        rd_wen_i  = 1'b1;
        valid_i   = 1'b1;
        for (int i = 1; i <= 9; i++) @(negedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b, required 0", stall_o);
        end
        @(negedge clk);
        flush_i = 1'b0;
        checks++;
        if (reg_wen_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_wb: got wen=%b, required 0", reg_wen_o);
        end
        issue1(r_op(7'h00, 3'd0), 32'd1, 32'd2, 5'd6, 1'b1, {1'b1, 32'd3});
        for (int i = 13; i <= 40; i++) begin
            @(negedge clk);
            checks++;
            if (reg_wen_o !== 1'b0 || stall_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet: cycle T+%0d got wen=%b stall=%b, required 0 0",
                         i, reg_wen_o, stall_o);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        inst_i    = r_op(7'h01, 3'd5);
        op1_i     = 32'd5000;
        op2_i     = 32'd3;
        rd_addr_i = 5'd27;
        rd_wen_i  = 1'b1;
        valid_i   = 1'b1;
        for (int i = 1; i <= 4; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stall: got %b, required 0", stall_o);
        end
        @(negedge clk);
        checks++;
        if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== 38'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got wen=%b waddr=%0d wdata=%h, required all 0",
                     reg_wen_o, reg_waddr_o, reg_wdata_o);
        end
        valid_i = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            checks++;
            if (reg_wen_o !== 1'b0 || stall_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_quiet: got wen=%b stall=%b, required 0 0", reg_wen_o, stall_o);
            end
        end
    endtask

    task automatic test_no_write();
        issue1(r_op(7'h00, 3'd0), 32'd5, 32'd7, 5'd0, 1'b1, {1'b1, 32'd12});
        issue1(r_op(7'h00, 3'd0), 32'd5, 32'd7, 5'd3, 1'b0, {1'b1, 32'd12});
        issue1(32'h0020_A023, 32'd5, 32'd7, 5'd3, 1'b1, {1'b0, 32'h0});
        issue1(r_op(7'h10, 3'd0), 32'd5, 32'd7, 5'd3, 1'b1, {1'b0, 32'h0});
        issue1(r_op(7'h01, 3'd5), 32'd9, 32'd0, 5'd0, 1'b1, {1'b1, 32'hFFFF_FFFF});
        issue1(r_op(7'h00, 3'd0), 32'd2, 32'd2, 5'd28, 1'b1, {1'b1, 32'd4});
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div_special();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        test_no_write();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32IM core.
- Consumes the two source operands read from the register file, plus the decoded instruction. Computes RV32I ALU results and RV32M multiply/divide results.
- Drives the register-file write port (waddr/wdata/wen) with a registered result.
- Divide/remainder runs iteratively. The stage raises stall_o so upstream holds its outputs while the divide is in progress.

Parameters:
- DIV_ITERS, 32, restoring-divider iteration count; fixed at data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- valid_i  in  1  inst_i/op1_i/op2_i carry a live instruction this cycle
- flush_i  in  1  cancel current and in-flight work
- inst_i  in  32  instruction word
- op1_i  in  32  rs1 value from register file
- op2_i  in  32  rs2 value from register file, or sign-extended I-imm for I-type (selected upstream)
- rd_addr_i  in  5  destination register
- rd_wen_i  in  1  instruction writes rd
- stall_o  out  1  upstream must hold all inputs stable
- reg_waddr_o  out  5  register-file write address
- reg_wdata_o  out  32  register-file write data
- reg_wen_o  out  1  register-file write enable, one-cycle pulse per result

Behaviour:
- Reset (rst=0 at posedge):
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - State IDLE; iteration counter 0.
  - stall_o=0 combinationally while rst=0.
- Decode:
  - opcode 0110011 with funct7 0000000/0100000: R-ALU.
  - opcode 0110011 with funct7 0000001: M-ext.
  - opcode 0010011: I-ALU.
  - opcode 0110111: LUI, result = {inst[31:12],12'b0}.
  - Any other opcode: no writeback (reg_wen_o=0 next cycle).
- ALU ops follow RV32I:
  - Shifts use op2[4:0].
  - SRA/SRAI is selected by inst[30].
  - SUB applies to R-type only (inst[30]).
  - SLT is signed; SLTU is unsigned.
- Multiply:
  - MUL = low 32 bits of the product.
  - MULH = signed×signed, high 32 bits.
  - MULHSU = signed×unsigned, high 32 bits.
  - MULHU = unsigned×unsigned, high 32 bits.
  - All via a 64-bit product, single cycle.
- Single-cycle latency, for ALU, MUL*, LUI and special-case divides:
  - valid_i=1 in cycle T → reg_wen_o=1 in T+1 with that cycle's waddr/wdata.
  - reg_wen_o = rd_wen_i && rd_addr_i!=0.
  - stall_o=0.
- Divide special cases, single-cycle, no stall:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000, REM → 0.
- Normal divide (DIV/DIVU/REM/REMU otherwise):
  - Cycle T, IDLE with valid_i: stall_o=1 combinationally. Latch magnitudes, sign flags, op type, rd, rd_wen. Go to DIV, counter=0.
  - Cycles T+1..T+32 (state DIV): one restoring step per cycle, counter increments.
  - stall_o=1 through T+32 and 0 from T+33.
  - Inputs are ignored in DIV state, so the held divide instruction is not re-accepted.
  - At the edge ending T+32: apply sign fix-up. Quotient is negative if the operand signs differ (signed ops only). Remainder takes the dividend's sign.
  - Then register the result and return to IDLE.
  - T+33: reg_wen_o pulse. Any new valid_i in T+33 is accepted normally.
- reg_wen_o is 0 in every cycle not listed above. waddr/wdata hold their last value when wen=0.
- flush_i=1:
  - Next cycle reg_wen_o=0.
  - State → IDLE; stall_o drops combinationally in the same cycle.
  - Overrides valid_i: nothing is accepted.
- Reset mid-divide: abort, no writeback, outputs return to reset values.
- Write to x0 computes but never asserts reg_wen_o.

Test Plan:
- ADD, op1=5, op2=7, rd=3, valid 1 cycle → next cycle reg_wen_o=1, waddr=3, wdata=12; stall_o=0 throughout.
- MULH, op1=0x80000000, op2=2 → wdata=0xFFFFFFFF. MULHU with the same operands → 0x00000001. MUL → 0x00000000.
- DIV, op1=0xFFFFFF9C (-100), op2=7, accepted cycle T → stall_o=1 for T..T+32; reg_wen_o pulses only at T+33, wdata=0xFFFFFFF2 (-14). Same case as REM → 0xFFFFFFFE (-2).
- DIVU by 0 → T+1 wdata=0xFFFFFFFF, stall_o never asserts. DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1.
- DIV started, flush_i at T+10 → stall_o=0 in T+10, no reg_wen_o pulse through T+40. ADD at T+11 writes at T+12.
- rst=0 at T+5 of a divide → all outputs 0 next cycle, no writeback. An ADD with rd=0 → reg_wen_o stays 0.
